cordic_iter_engine: RTL and testbench

- Parametrised iterative CORDIC engine; next generation of the hand-placed first-stage X slices.
- Generalises the fixed 8-bit pos/neg select-and-add slice to configurable X/Y/Z widths and iteration count.
- Adds rotation and vectoring modes and a start/busy/done handshake.
- Sits between the angle/vector source and downstream sin/cos or magnitude/phase consumers; one X/Y/Z datapath reused over ITER cycles.

---
 rtl/cordic_pkg.sv | 62 ++++++
 rtl/cordic_xy_stage.sv | 45 ++++
 rtl/cordic_iter_engine.sv | 259 +++++++++++++++++++++++++
 tb/tb_cordic_iter_engine.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_pkg
// Purpose  : Shared definitions for the iterative CORDIC engine.
//            - FSM state encoding
//            - arctangent table generator (binary angle units, 2^zw = 360 deg)
//            - quadrant constant generator (2^(zw-2) = 90 deg)
// Notes    : The table functions run at elaboration time only. They use wide
//            integer arithmetic so that no real-number math is needed.
//            Angle widths up to 64 bits are supported.
// Revision : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PREROT = 2'd1,
        S_ITER   = 2'd2,
        S_DONE   = 2'd3
    } cordic_state_e;

    // Fraction bits used while the arctangent series is evaluated.
    localparam int ATAN_FRAC = 60;

    // 2*pi in Q60: 6.487ED5110B4611A6... (hex), truncated to 60 fraction bits.
    localparam logic [63:0] TWO_PI_Q60 = 64'h6487_ED51_10B4_611A;

    // Quarter turn (90 deg) for an angle word of width zw.
    function automatic logic [63:0] quarter(input int zw);
        return 64'd1 << (zw - 2);
    endfunction

    // round(atan(2^-i) / (2*pi) * 2^zw).
    // i = 0 is exactly one eighth of a turn. Every other entry sums the
    // Taylor series x - x^3/3 + x^5/5 ... with x = 2^-i, in Q60, and then
    // rescales the sum to binary angle units with round-half-up.
    function automatic logic [63:0] atan_entry(input int i, input int zw);
        logic [255:0] acc;
        logic [255:0] term;
        logic [255:0] num;
        int           sh;
        if (i == 0) begin
            return 64'd1 << (zw - 3);
        end
        acc = '0;
        for (int k = 0; k < 64; k++) begin
            sh = i * (2 * k + 1);
            if (sh <= ATAN_FRAC) begin
                term = (256'd1 << (ATAN_FRAC - sh)) / 256'(2 * k + 1);
                if (k[0]) begin
                    acc = acc - term;
                end else begin
                    acc = acc + term;
                end
            end
        end
        num = (acc << zw) + {192'd0, TWO_PI_Q60 >> 1};
        return 64'(num / {192'd0, TWO_PI_Q60});
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_xy_stage.sv
`default_nettype none
// ============================================================================
// Module   : cordic_xy_stage
// Purpose  : One combinational CORDIC micro-rotation. The engine instances it
//            once and feeds it back through its X/Y/Z registers.
//              d = +1 : x' = x - (y>>>i), y' = y + (x>>>i), z' = z - atan
//              d = -1 : x' = x + (y>>>i), y' = y - (x>>>i), z' = z + atan
//            All sums wrap modulo their width.
// Ports    : i_x, i_y   signed XW-bit current vector
//            i_z        ZW-bit current angle
//            i_d_pos    1 selects d = +1, 0 selects d = -1
//            i_shift    iteration index i (arithmetic shift amount)
//            i_atan     ATAN[i] for this iteration
//            o_x, o_y   rotated vector
//            o_z        updated angle
// Revision : 1.0 - initial release
// ============================================================================
module cordic_xy_stage #(
    parameter int XW = 18,
    parameter int ZW = 32,
    parameter int IW = 4
) (
    input  logic signed [XW-1:0] i_x,
    input  logic signed [XW-1:0] i_y,
    input  logic        [ZW-1:0] i_z,
    input  logic                 i_d_pos,
    input  logic        [IW-1:0] i_shift,
    input  logic        [ZW-1:0] i_atan,
    output logic signed [XW-1:0] o_x,
    output logic signed [XW-1:0] o_y,
    output logic        [ZW-1:0] o_z
);

    logic signed [XW-1:0] w_x_sh;
    logic signed [XW-1:0] w_y_sh;

    assign w_x_sh = i_x >>> i_shift;
    assign w_y_sh = i_y >>> i_shift;

    assign o_x = i_d_pos ? (i_x - w_y_sh) : (i_x + w_y_sh);
    assign o_y = i_d_pos ? (i_y + w_x_sh) : (i_y - w_x_sh);
    assign o_z = i_d_pos ? (i_z - i_atan) : (i_z + i_atan);

endmodule
`default_nettype wire

// File: rtl/cordic_iter_engine.sv
`default_nettype none
// ============================================================================
// Module   : cordic_iter_engine
// Purpose  : Iterative CORDIC engine with rotation and vectoring modes.
//            A single X/Y/Z datapath is reused for ITER micro-rotations.
//            The engine applies no gain compensation, so the outputs carry
//            K ~= 1.6468.
// Params   : W    signed X/Y input width (internal and output width W+2)
//            ZW   angle width in binary angle units (2^ZW = 360 deg)
//            ITER number of micro-rotations, 1..min(W+2, ZW)
// Ports    : C          clock, rising edge
//            RSTN       synchronous reset, active low, overrides CE
//            CE         clock enable; low freezes every register
//            start      job request, taken only in IDLE
//            mode       0 = rotation (drive Z to 0), 1 = vectoring (Y to 0)
//            x_in,y_in  signed W-bit input vector
//            z_in       ZW-bit input angle
//            busy       high from the cycle after accept until done
//            done       one CE-cycle pulse; results valid
//            x_out,y_out,z_out  results, held until the next done
// Macro    : CORDIC_QUAD_PREROT_EN - adds a one-cycle quadrant pre-rotation
//            that extends convergence to the full +/-180 deg range.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_iter_engine
    import cordic_pkg::*;
#(
    parameter int W    = 16,
    parameter int ZW   = 32,
    parameter int ITER = 16
) (
    input  logic                C,
    input  logic                RSTN,
    input  logic                CE,
    input  logic                start,
    input  logic                mode,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    input  logic       [ZW-1:0] z_in,
    output logic                busy,
    output logic                done,
    output logic signed [W+1:0] x_out,
    output logic signed [W+1:0] y_out,
    output logic       [ZW-1:0] z_out
);

    localparam int            XW     = W + 2;
    localparam int            IW     = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [IW-1:0] C_LAST = IW'(ITER - 1);

    cordic_state_e        r_state;
    cordic_state_e        w_state_nxt;
    logic                 w_accept;
    logic                 w_finish;

    logic signed [XW-1:0] r_x;
    logic signed [XW-1:0] r_y;
    logic        [ZW-1:0] r_z;
    logic                 r_mode;
    logic        [IW-1:0] r_iter;
    logic                 r_busy;
    logic                 r_done;
    logic signed [XW-1:0] r_x_out;
    logic signed [XW-1:0] r_y_out;
    logic        [ZW-1:0] r_z_out;

    logic                 w_d_pos;
    logic        [ZW-1:0] w_atan;
    logic signed [XW-1:0] w_stg_x;
    logic signed [XW-1:0] w_stg_y;
    logic        [ZW-1:0] w_stg_z;

    // ------------------------------------------------------------------
    // Arctangent ROM, one constant entry per iteration
    // ------------------------------------------------------------------
    logic [ZW-1:0] w_atan_rom [ITER];

    for (genvar g = 0; g < ITER; g++) begin : g_atan
        localparam logic [63:0] C_ATAN64 = atan_entry(g, ZW);
        assign w_atan_rom[g] = C_ATAN64[ZW-1:0];
    end

    assign w_atan = w_atan_rom[r_iter];

    // ------------------------------------------------------------------
    // Micro-rotation direction.
    // Rotation drives z toward 0. Vectoring drives y toward 0 and
    // accumulates the vector angle into z.
    // ------------------------------------------------------------------
    assign w_d_pos = r_mode ? r_y[XW-1] : ~r_z[ZW-1];

    cordic_xy_stage #(
        .XW (XW),
        .ZW (ZW),
        .IW (IW)
    ) u_stage (
        .i_x     (r_x),
        .i_y     (r_y),
        .i_z     (r_z),
        .i_d_pos (w_d_pos),
        .i_shift (r_iter),
        .i_atan  (w_atan),
        .o_x     (w_stg_x),
        .o_y     (w_stg_y),
        .o_z     (w_stg_z)
    );

`ifdef CORDIC_QUAD_PREROT_EN
    // ------------------------------------------------------------------
    // Quadrant pre-rotation by +/-90 deg. After this step the residual
    // angle (rotation) or the vector (vectoring) lies in the right
    // half-plane, where the micro-rotations converge.
    // ------------------------------------------------------------------
    localparam logic [63:0]   C_QUARTER64 = quarter(ZW);
    localparam logic [ZW-1:0] C_QUARTER   = C_QUARTER64[ZW-1:0];

    logic signed [XW-1:0] w_pre_x;
    logic signed [XW-1:0] w_pre_y;
    logic        [ZW-1:0] w_pre_z;

    always_comb begin
        w_pre_x = r_x;
        w_pre_y = r_y;
        w_pre_z = r_z;
        if (!r_mode) begin
            if (r_z[ZW-1:ZW-2] == 2'b01) begin
                w_pre_x = -r_y;
                w_pre_y = r_x;
                w_pre_z = r_z - C_QUARTER;
            end else if (r_z[ZW-1:ZW-2] == 2'b10) begin
                w_pre_x = r_y;
                w_pre_y = -r_x;
                w_pre_z = r_z + C_QUARTER;
            end
        end else if (r_x[XW-1]) begin
            if (!r_y[XW-1]) begin
                w_pre_x = r_y;
                w_pre_y = -r_x;
                w_pre_z = r_z + C_QUARTER;
            end else begin
                w_pre_x = -r_y;
                w_pre_y = r_x;
                w_pre_z = r_z - C_QUARTER;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge C) begin
        if (!RSTN) begin
            r_state <= S_IDLE;
        end else if (CE) begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
`ifdef CORDIC_QUAD_PREROT_EN
                    w_state_nxt = S_PREROT;
`else
                    w_state_nxt = S_ITER;
`endif
                end
            end
            S_PREROT: begin
                w_state_nxt = S_ITER;
            end
            S_ITER: begin
                if (r_iter == C_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_finish    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge C) begin
        if (!RSTN) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_mode  <= 1'b0;
            r_iter  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_x_out <= '0;
            r_y_out <= '0;
            r_z_out <= '0;
        end else if (CE) begin
            // done is high only in the cycle after DONE
            r_done <= w_finish;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x    <= {{2{x_in[W-1]}}, x_in};
                        r_y    <= {{2{y_in[W-1]}}, y_in};
                        r_z    <= z_in;
                        r_mode <= mode;
                        r_iter <= '0;
                        r_busy <= 1'b1;
                    end
                end
`ifdef CORDIC_QUAD_PREROT_EN
                S_PREROT: begin
                    r_x <= w_pre_x;
                    r_y <= w_pre_y;
                    r_z <= w_pre_z;
                end
`endif
                S_ITER: begin
                    r_x <= w_stg_x;
                    r_y <= w_stg_y;
                    r_z <= w_stg_z;
                    if (r_iter != C_LAST) begin
                        r_iter <= r_iter + 1'b1;
                    end
                end
                S_DONE: begin
                    r_x_out <= r_x;
                    r_y_out <= r_y;
                    r_z_out <= r_z;
                    r_busy  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign x_out = r_x_out;
    assign y_out = r_y_out;
    assign z_out = r_z_out;

endmodule
`default_nettype wire

// File: tb/tb_cordic_iter_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_iter_engine
// Purpose  : Self-checking bench for cordic_iter_engine. A behavioural model
//            built on real-number arctangents predicts every result bit for
//            bit. Directed cases cover rotation, vectoring, start while busy,
//            CE stalls, and mid-job reset. Seeded random jobs follow them.
// Macro    : CORDIC_QUAD_PREROT_EN - when defined, the expected latency and
//            the model include the quadrant pre-rotation, and the random
//            jobs span the full angle range.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cordic_iter_engine;

    localparam int W    = 16;
    localparam int ZW   = 32;
    localparam int ITER = 16;
    localparam int XW   = W + 2;
`ifdef CORDIC_QUAD_PREROT_EN
    localparam int LAT  = ITER + 2;
`else
    localparam int LAT  = ITER + 1;
`endif

    logic                 C     = 1'b0;
    logic                 RSTN  = 1'b0;
    logic                 CE    = 1'b1;
    logic                 start = 1'b0;
    logic                 mode  = 1'b0;
    logic signed [W-1:0]  x_in  = '0;
    logic signed [W-1:0]  y_in  = '0;
    logic        [ZW-1:0] z_in  = '0;
    logic                 busy;
    logic                 done;
    logic signed [XW-1:0] x_out;
    logic signed [XW-1:0] y_out;
    logic        [ZW-1:0] z_out;

    int     total = 0;
    int     bad   = 0;
    longint atan_tab [ITER];

    always #5 C = ~C;

    cordic_iter_engine #(.W(W), .ZW(ZW), .ITER(ITER)) dut (
        .C     (C),
        .RSTN  (RSTN),
        .CE    (CE),
        .start (start),
        .mode  (mode),
        .x_in  (x_in),
        .y_in  (y_in),
        .z_in  (z_in),
        .busy  (busy),
        .done  (done),
        .x_out (x_out),
        .y_out (y_out),
        .z_out (z_out)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic signed [63:0] obs,
                              input logic signed [63:0] exp, input longint tol);
        total++;
        assert (((obs >= exp - tol) && (obs <= exp + tol)) === 1'b1) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, exp, tol);
        end
    endtask

    // Reference: optional quadrant fold followed by ITER textbook CORDIC
    // steps on W+2-bit wrapping integers and a ZW-bit wrapping angle.
    task automatic model(input logic signed [W-1:0] xi, input logic signed [W-1:0] yi,
                         input logic [ZW-1:0] zi, input logic md,
                         output logic signed [XW-1:0] xo, output logic signed [XW-1:0] yo,
                         output logic [ZW-1:0] zo);
        logic signed [XW-1:0] x, y, xn, yn, t;
        logic        [ZW-1:0] z, q;
        logic                 dpos;
        x = xi;
        y = yi;
        z = zi;
        q = ZW'(1) << (ZW - 2);
`ifdef CORDIC_QUAD_PREROT_EN
        if (!md) begin
            if (z[ZW-1:ZW-2] == 2'b01) begin
                t = x; x = -y; y = t; z = z - q;
            end else if (z[ZW-1:ZW-2] == 2'b10) begin
                t = x; x = y; y = -t; z = z + q;
            end
        end else if (x < 0) begin
            if (y >= 0) begin
                t = x; x = y; y = -t; z = z + q;
            end else begin
                t = x; x = -y; y = t; z = z - q;
            end
        end
`else
        t = '0;
`endif
        for (int i = 0; i < ITER; i++) begin
            dpos = md ? (y < 0) : (z[ZW-1] == 1'b0);
            if (dpos) begin
                xn = x - (y >>> i);
                yn = y + (x >>> i);
                z  = z - ZW'(atan_tab[i]);
            end else begin
                xn = x + (y >>> i);
                yn = y - (x >>> i);
                z  = z + ZW'(atan_tab[i]);
            end
            x = xn;
            y = yn;
        end
        xo = x;
        yo = y;
        zo = z;
    endtask

    task automatic check_model(input string tag, input logic signed [W-1:0] xi,
                               input logic signed [W-1:0] yi, input logic [ZW-1:0] zi,
                               input logic md);
        logic signed [XW-1:0] ex, ey;
        logic        [ZW-1:0] ez;
        model(xi, yi, zi, md, ex, ey, ez);
        check({tag, ".x"}, x_out, ex);
        check({tag, ".y"}, y_out, ey);
        check({tag, ".z"}, z_out, ez);
    endtask

    // Issue one job and wait, with a bound, for done. lat is the number of
    // CE edges from accept to done high, or -1 when the bound expires.
    task automatic do_job(input logic signed [W-1:0] xi, input logic signed [W-1:0] yi,
                          input logic [ZW-1:0] zi, input logic md, output int lat);
        x_in  = xi;
        y_in  = yi;
        z_in  = zi;
        mode  = md;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = -1;
        for (int k = 1; k <= LAT + 40; k++) begin
            tick();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int                   lat;
        int                   n_done;
        int                   tmp;
        logic signed [W-1:0]  rx, ry;
        logic        [ZW-1:0] rz;
        logic                 rm;
        logic signed [XW-1:0] hx;

        for (int i = 0; i < ITER; i++) begin
            atan_tab[i] = longint'($floor($atan(1.0 / (2.0 ** i)) /
                          (2.0 * 3.14159265358979323846) * (2.0 ** ZW) + 0.5));
        end

        // ---------------- reset state ----------------
        RSTN = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_x", x_out, 0);
        check("rst_y", y_out, 0);
        check("rst_z", z_out, 0);
        RSTN = 1'b1;
        tick();

        // ---------------- rotation 45 deg ----------------
        do_job(16'sd16384, 16'sd0, 32'h2000_0000, 1'b0, lat);
        check("rot45_lat", lat, LAT);
        check_near("rot45_x", x_out, 19079, 4);
        check_near("rot45_y", y_out, 19079, 4);
        check_near("rot45_z", $signed(z_out), 0, 64'h10000);
        check_model("rot45", 16'sd16384, 16'sd0, 32'h2000_0000, 1'b0);
        tick();
        check("done_one_cycle", done, 0);

        // ---------------- vectoring ----------------
        do_job(16'sd10000, 16'sd10000, 32'h0, 1'b1, lat);
        check("vec_lat", lat, LAT);
        check_near("vec_x", x_out, 23290, 4);
        check_near("vec_y", y_out, 0, 4);
        check_near("vec_z", z_out, 64'h2000_0000, 64'h10000);
        check_model("vec", 16'sd10000, 16'sd10000, 32'h0, 1'b1);

`ifdef CORDIC_QUAD_PREROT_EN
        // ---------------- 90 deg rotation through pre-rotation ----------------
        do_job(16'sd10000, 16'sd0, 32'h4000_0000, 1'b0, lat);
        check("pre90_lat", lat, ITER + 2);
        check_near("pre90_x", x_out, 0, 4);
        check_near("pre90_y", y_out, 16468, 4);
        check_model("pre90", 16'sd10000, 16'sd0, 32'h4000_0000, 1'b0);
`endif

        // ---------------- start while busy is ignored ----------------
        x_in  = 16'sd12000;
        y_in  = -16'sd3000;
        z_in  = 32'h1800_0000;
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start  = 1'b0;
        n_done = 0;
        lat    = -1;
        for (int k = 1; k <= LAT + 10; k++) begin
            if (k == 5) begin
                x_in  = -16'sd5000;
                y_in  = 16'sd7000;
                z_in  = 32'hF000_0000;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (lat < 0) lat = k;
            end
        end
        check("busy_start_ndone", n_done, 1);
        check("busy_start_lat", lat, LAT);
        check("busy_start_idle", busy, 0);
        check_model("busy_start", 16'sd12000, -16'sd3000, 32'h1800_0000, 1'b0);
        do_job(-16'sd5000, 16'sd7000, 32'hF000_0000, 1'b0, lat);
        check("second_job_lat", lat, LAT);
        check_model("second_job", -16'sd5000, 16'sd7000, 32'hF000_0000, 1'b0);

        // ---------------- CE stall of 7 cycles mid-iteration ----------------
        x_in  = 16'sd16384;
        y_in  = 16'sd0;
        z_in  = 32'h2000_0000;
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = -1;
        for (int k = 1; k <= LAT + 30; k++) begin
            if (k == 5)  CE = 1'b0;
            if (k == 12) CE = 1'b1;
            tick();
            if (k == 8) check("stall_busy_held", busy, 1);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("stall_lat", lat, LAT + 7);
        check_model("stall", 16'sd16384, 16'sd0, 32'h2000_0000, 1'b0);
        hx = x_out;
        CE = 1'b0;
        repeat (3) tick();
        check("ce0_done_held", done, 1);
        check("ce0_x_held", x_out, hx);
        CE = 1'b1;
        tick();
        check("ce1_done_drop", done, 0);

        // ---------------- reset during a job ----------------
        x_in  = 16'sd9000;
        y_in  = 16'sd4000;
        z_in  = 32'h0800_0000;
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_x", x_out, 0);
        check("midrst_y", y_out, 0);
        check("midrst_z", z_out, 0);
        n_done = 0;
        for (int k = 0; k < LAT + 10; k++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        check("midrst_no_done", n_done, 0);
        do_job(16'sd9000, 16'sd4000, 32'h0800_0000, 1'b0, lat);
        check("after_rst_lat", lat, LAT);
        check_model("after_rst", 16'sd9000, 16'sd4000, 32'h0800_0000, 1'b0);

        // ---------------- random jobs ----------------
        for (int j = 0; j < 24; j++) begin
            rm  = 1'($urandom_range(0, 1));
            tmp = int'($urandom_range(0, 60000)) - 30000;
            ry  = W'(tmp);
            rz  = ZW'($urandom);
`ifdef CORDIC_QUAD_PREROT_EN
            tmp = int'($urandom_range(0, 60000)) - 30000;
            rx  = W'(tmp);
`else
            if (rm) begin
                tmp = int'($urandom_range(1, 30000));
            end else begin
                tmp = int'($urandom_range(0, 60000)) - 30000;
            end
            rx = W'(tmp);
            rz = {rz[ZW-1], rz[ZW-1], rz[ZW-3:0]};
`endif
            do_job(rx, ry, rz, rm, lat);
            check($sformatf("rand%0d_lat", j), lat, LAT);
            check_model($sformatf("rand%0d", j), rx, ry, rz, rm);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
